// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions for the fetch stage: default widths, halt opcode,
// FSM state encoding and the saturating counter helper.
package fetch_unit_pkg;

  localparam int          FU_ADDR_W  = 6;
  localparam int          FU_INSTR_W = 16;
  localparam logic [3:0]  FU_HALT_OP = 4'hF;
  localparam int          FU_COUNT_W = 16;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  function automatic logic [FU_COUNT_W-1:0] sat_inc(input logic [FU_COUNT_W-1:0] v);
    if (v == {FU_COUNT_W{1'b1}}) return v;
    return v + FU_COUNT_W'(1);
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: load has priority over increment, otherwise hold.
module pc_reg
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = FU_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Increment wraps naturally at 2^ADDR_W.
  always_comb begin
    pc_d = pc_q;
    if (load)     pc_d = load_val;
    else if (inc) pc_d = pc_q + ADDR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, BOOT/RUN/HALTED control, IF/ID register and a
// saturating count of delivered instructions.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int         ADDR_W  = FU_ADDR_W,
  parameter int         INSTR_W = FU_INSTR_W,
  parameter logic [3:0] HALT_OP = FU_HALT_OP
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [INSTR_W-1:0]    rom_instr,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_W-1:0]     redirect_target,
  output logic                  ifid_valid,
  output logic [INSTR_W-1:0]    ifid_instr,
  output logic [ADDR_W-1:0]     ifid_pc,
  output logic                  halted,
  output logic [FU_COUNT_W-1:0] fetch_count
);

  fetch_state_e          state_q, state_d;
  logic                  ifid_valid_q, ifid_valid_d;
  logic [INSTR_W-1:0]    ifid_instr_q, ifid_instr_d;
  logic [ADDR_W-1:0]     ifid_pc_q, ifid_pc_d;
  logic                  halted_q, halted_d;
  logic [FU_COUNT_W-1:0] fetch_count_q, fetch_count_d;

  logic              pc_inc;
  logic              pc_load;
  logic [ADDR_W-1:0] pc;
  logic              is_halt;

  pc_reg #(.ADDR_W(ADDR_W)) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (pc_inc),
    .load     (pc_load),
    .load_val (redirect_target),
    .pc       (pc)
  );

  assign rom_addr = pc;
  assign is_halt  = (rom_instr[INSTR_W-1 -: 4] == HALT_OP);

  always_comb begin
    state_d       = state_q;
    ifid_valid_d  = ifid_valid_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_pc_d     = ifid_pc_q;
    halted_d      = halted_q;
    fetch_count_d = fetch_count_q;
    pc_inc        = 1'b0;
    pc_load       = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        // A redirect squashes the fetch at the old PC, so a wrong-path halt never stops us.
        if (redirect_valid) begin
          pc_load      = 1'b1;
          ifid_valid_d = 1'b0;
        end else if (!stall) begin
          pc_inc        = 1'b1;
          ifid_valid_d  = 1'b1;
          ifid_instr_d  = rom_instr;
          ifid_pc_d     = pc;
          fetch_count_d = sat_inc(fetch_count_q);
          if (is_halt) begin
            state_d  = ST_HALTED;
            halted_d = 1'b1;
          end
        end
      end
      ST_HALTED: ifid_valid_d = 1'b0;
      default:   state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      ifid_valid_q  <= 1'b0;
      ifid_instr_q  <= '0;
      ifid_pc_q     <= '0;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ifid_valid_q  <= ifid_valid_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_pc_q     <= ifid_pc_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign ifid_valid  = ifid_valid_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_pc     = ifid_pc_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then randomized stall/redirect/memory
// traffic, every output compared each cycle against a behavioural model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  rom_addr;
  logic [15:0] rom_instr;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [5:0]  redirect_target = '0;
  logic        ifid_valid;
  logic [15:0] ifid_instr;
  logic [5:0]  ifid_pc;
  logic        halted;
  logic [15:0] fetch_count;

  logic [15:0] mem [64];

  int n_vec = 0;
  int n_err = 0;

  localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;
  int          m_mode;
  logic [5:0]  m_pc;
  logic [5:0]  m_ifpc;
  logic [15:0] m_instr;
  bit          m_vld;
  bit          m_halted;
  int          m_cnt;

  fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rom_addr        (rom_addr),
    .rom_instr       (rom_instr),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .ifid_valid      (ifid_valid),
    .ifid_instr      (ifid_instr),
    .ifid_pc         (ifid_pc),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  assign rom_instr = mem[rom_addr];

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish before 2ms");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_BOOT; m_pc = '0; m_ifpc = '0; m_instr = '0;
    m_vld = 0; m_halted = 0; m_cnt = 0;
  endtask

  // One clock of the fetch rules, applied to the state seen before the edge.
  task automatic model_step(input bit s, input bit r, input logic [5:0] t);
    logic [15:0] word;
    word = mem[m_pc];
    if (m_mode == M_BOOT) begin
      m_mode = M_RUN;
    end else if (m_mode == M_HALT) begin
      m_vld = 0;
    end else if (r) begin
      m_pc  = t;
      m_vld = 0;
    end else if (!s) begin
      m_instr = word;
      m_ifpc  = m_pc;
      m_vld   = 1;
      if (m_cnt < 65535) m_cnt++;
      if (word[15:12] == 4'hF) begin
        m_mode = M_HALT;
        m_halted = 1;
      end
      m_pc = 6'((int'(m_pc) + 1) % 64);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".rom_addr"},    32'(rom_addr),    32'(m_pc));
    check({tag, ".ifid_valid"},  32'(ifid_valid),  32'(m_vld));
    check({tag, ".ifid_instr"},  32'(ifid_instr),  32'(m_instr));
    check({tag, ".ifid_pc"},     32'(ifid_pc),     32'(m_ifpc));
    check({tag, ".halted"},      32'(halted),      32'(m_halted));
    check({tag, ".fetch_count"}, 32'(fetch_count), 32'(m_cnt));
  endtask

  task automatic step(input bit s, input bit r, input logic [5:0] t);
    stall = s; redirect_valid = r; redirect_target = t;
    model_step(s, r, t);
    @(posedge clk);
    #1;
    compare_all("step");
  endtask

  // Assert reset away from the clock edge, confirm the immediate clear, release later.
  task automatic do_reset(input int offset);
    #(offset);
    rst_n = 1'b0;
    stall = 0; redirect_valid = 0; redirect_target = '0;
    #1;
    model_reset();
    compare_all("rst_async");
    @(posedge clk);
    #1;
    compare_all("rst_held");
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int idle_halt;
    for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i + 1);
    mem[63] = 16'h2000;
    mem[5]  = 16'hF000;
    model_reset();

    // Power-on reset and straight-line fetch of 0..2.
    #3;
    do_reset(1);
    step(0, 0, 0);
    check("boot_vld", 32'(ifid_valid), 32'h0);
    check("boot_addr", 32'(rom_addr), 32'h0);
    step(0, 0, 0);
    check("e2_instr", 32'(ifid_instr), 32'h1001);
    step(0, 0, 0);
    check("e3_instr", 32'(ifid_instr), 32'h1002);
    step(0, 0, 0);
    check("e4_instr", 32'(ifid_instr), 32'h1003);
    check("e4_pc", 32'(ifid_pc), 32'h2);
    check("e4_cnt", 32'(fetch_count), 32'h3);

    for (int i = 0; i < 3; i++) step(1, 0, 0);
    check("stall_addr", 32'(rom_addr), 32'h3);
    check("stall_instr", 32'(ifid_instr), 32'h1003);
    check("stall_cnt", 32'(fetch_count), 32'h3);

    // Redirect wins over stall, then run to the top of memory and wrap.
    step(1, 1, 6'd40);
    check("redir_vld", 32'(ifid_valid), 32'h0);
    check("redir_addr", 32'(rom_addr), 32'd40);
    step(0, 0, 0);
    check("redir_pc", 32'(ifid_pc), 32'd40);
    for (int k = 0; k < 70 && m_pc != 6'd63; k++) step(0, 0, 0);
    step(0, 0, 0);
    check("wrap_ifpc", 32'(ifid_pc), 32'd63);
    check("wrap_instr", 32'(ifid_instr), 32'h2000);
    check("wrap_addr", 32'(rom_addr), 32'h0);
    step(0, 0, 0);
    check("wrap_ifpc0", 32'(ifid_pc), 32'h0);

    // Halt fetched under a redirect (target == PC) is wrong-path; the next fetch halts.
    step(0, 1, 6'd5);
    step(0, 1, 6'd5);
    check("wrongpath_halt", 32'(halted), 32'h0);
    check("refetch_addr", 32'(rom_addr), 32'd5);
    step(0, 0, 0);
    check("halt_instr", 32'(ifid_instr), 32'hF000);
    check("halt_vld", 32'(ifid_valid), 32'h1);
    step(1, 1, 6'd20);
    check("halted", 32'(halted), 32'h1);
    check("halted_vld", 32'(ifid_valid), 32'h0);
    check("halted_addr", 32'(rom_addr), 32'd6);
    step(0, 1, 6'd9);
    check("halted_addr2", 32'(rom_addr), 32'd6);
    do_reset(3);

    // Randomized traffic with occasional asynchronous resets.
    idle_halt = 0;
    for (int it = 0; it < 3000; it++) begin
      if ($urandom_range(0, 99) == 0)
        for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
      if (m_mode == M_HALT) idle_halt++;
      else idle_halt = 0;
      if (idle_halt > 3 || $urandom_range(0, 199) == 0) begin
        do_reset($urandom_range(1, 6));
        idle_halt = 0;
      end else begin
        step($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, 6'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
